// File: rtl/wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb : writeback stage - load completion, register-file write, instret     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package wb_cfg_pkg;
    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int MEM_OP_W   = 4;
    localparam int DEST_SRC_W = 2;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_SRC_NONE = 2'd0,
        DEST_SRC_ALU  = 2'd1,
        DEST_SRC_MEM  = 2'd2
    } dest_src_e;
endpackage

module wb
    import wb_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  stall,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [WORD_W-1:0]     i_alu_result,
    input  logic [MEM_OP_W-1:0]   i_mem_op,
    input  logic [DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]  i_dest_reg,
    input  logic [WORD_W-1:0]     i_dmem_rdata,
    input  logic                  i_dmem_rvalid,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic                  o_wb_dest_en,
    output logic [REG_IDX_W-1:0]  o_wb_dest_reg,
    output logic [WORD_W-1:0]     o_wb_dest_data,
    output logic                  o_stall_req,
    output logic [63:0]           o_instret
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_LOAD_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_valid;
    logic [ADDR_W-1:0]     r_pc;
    logic [INSTR_W-1:0]    r_instr;
    logic [WORD_W-1:0]     r_alu;
    logic [MEM_OP_W-1:0]   r_mem_op;
    logic [DEST_SRC_W-1:0] r_dest_src;
    logic [REG_IDX_W-1:0]  r_dest_reg;
    logic [WORD_W-1:0]     r_ld;
    logic                  r_counted;
    logic [63:0]           r_instret;

    logic                  w_capture;
    logic                  w_in_is_load;
    logic                  w_count;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WORD_W-1:0]     w_ld_data;

    assign w_capture    = ~clr & ~stall & (r_state != ST_LOAD_WAIT);
    assign w_in_is_load = i_valid & (i_mem_op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW,
                                                      MEM_OP_LBU, MEM_OP_LHU});
    // The counted flag keeps a stalled instruction from retiring more than once.
    assign w_count      = r_valid & (r_state != ST_LOAD_WAIT) & ~r_counted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture && w_in_is_load) begin
                        w_state_next = ST_LOAD_WAIT;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (i_dmem_rvalid) begin
                        w_state_next = ST_LOAD_DONE;
                    end
                end
                ST_LOAD_DONE: begin
                    w_state_next = (w_capture && w_in_is_load) ? ST_LOAD_WAIT : ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_alu      <= '0;
            r_mem_op   <= '0;
            r_dest_src <= '0;
            r_dest_reg <= '0;
        end else if (clr) begin
            r_valid    <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= i_valid;
            r_pc       <= i_pc;
            r_instr    <= i_instr;
            r_alu      <= i_alu_result;
            r_mem_op   <= i_mem_op;
            r_dest_src <= i_dest_src;
            r_dest_reg <= i_dest_reg;
        end
    end

    // Little-endian lane select; halfwords ignore address bit 0, words ignore both.
    always_comb begin
        w_byte    = i_dmem_rdata[{r_alu[1:0], 3'b000} +: 8];
        w_half    = i_dmem_rdata[{r_alu[1], 4'b0000} +: 16];
        w_ld_data = i_dmem_rdata;
        case (r_mem_op)
            MEM_OP_LB:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: w_ld_data = {24'd0, w_byte};
            MEM_OP_LH:  w_ld_data = {{16{w_half[15]}}, w_half};
            MEM_OP_LHU: w_ld_data = {16'd0, w_half};
            default:    w_ld_data = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld <= '0;
        end else if (!clr && (r_state == ST_LOAD_WAIT) && i_dmem_rvalid) begin
            r_ld <= w_ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counted <= 1'b0;
            r_instret <= 64'd0;
        end else begin
            if (clr || w_capture) begin
                r_counted <= 1'b0;
            end else if (w_count) begin
                r_counted <= 1'b1;
            end
            if (w_count) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_instr        = r_instr;
    assign o_wb_dest_reg  = r_dest_reg;
    assign o_wb_dest_data = (r_dest_src == DEST_SRC_MEM) ? r_ld : r_alu;
    assign o_wb_dest_en   = r_valid & (r_dest_reg != '0) & (r_dest_src != DEST_SRC_NONE)
                          & (r_state != ST_LOAD_WAIT);
    assign o_stall_req    = (r_state == ST_LOAD_WAIT);
    assign o_instret      = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb.sv
`default_nettype none
// Directed bench for wb: expected writes queued at issue, popped when the write appears.

module tb_wb;
    import wb_cfg_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clr = 1'b0;
    logic                  stall = 1'b0;
    logic                  i_valid = 1'b0;
    logic [ADDR_W-1:0]     i_pc = '0;
    logic [INSTR_W-1:0]    i_instr = '0;
    logic [WORD_W-1:0]     i_alu_result = '0;
    logic [MEM_OP_W-1:0]   i_mem_op = '0;
    logic [DEST_SRC_W-1:0] i_dest_src = '0;
    logic [REG_IDX_W-1:0]  i_dest_reg = '0;
    logic [WORD_W-1:0]     i_dmem_rdata = '0;
    logic                  i_dmem_rvalid = 1'b0;
    logic [ADDR_W-1:0]     o_pc;
    logic [INSTR_W-1:0]    o_instr;
    logic                  o_wb_dest_en;
    logic [REG_IDX_W-1:0]  o_wb_dest_reg;
    logic [WORD_W-1:0]     o_wb_dest_data;
    logic                  o_stall_req;
    logic [63:0]           o_instret;

    always #5 clk = ~clk;

    wb dut (
        .clk            (clk),
        .reset          (reset),
        .clr            (clr),
        .stall          (stall),
        .i_valid        (i_valid),
        .i_pc           (i_pc),
        .i_instr        (i_instr),
        .i_alu_result   (i_alu_result),
        .i_mem_op       (i_mem_op),
        .i_dest_src     (i_dest_src),
        .i_dest_reg     (i_dest_reg),
        .i_dmem_rdata   (i_dmem_rdata),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .o_pc           (o_pc),
        .o_instr        (o_instr),
        .o_wb_dest_en   (o_wb_dest_en),
        .o_wb_dest_reg  (o_wb_dest_reg),
        .o_wb_dest_data (o_wb_dest_data),
        .o_stall_req    (o_stall_req),
        .o_instret      (o_instret)
    );

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [WORD_W-1:0]    data;
    } wr_t;

    wr_t         sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_instret = 64'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [MEM_OP_W-1:0] op,
                         input logic [DEST_SRC_W-1:0] src, input logic [REG_IDX_W-1:0] rd,
                         input logic [WORD_W-1:0] alu, input logic [ADDR_W-1:0] pc);
        i_valid      = v;
        i_mem_op     = op;
        i_dest_src   = src;
        i_dest_reg   = rd;
        i_alu_result = alu;
        i_pc         = pc;
        i_instr      = pc ^ 32'h0000_0013;
    endtask

    task automatic bubble();
        drive(1'b0, MEM_OP_NONE, DEST_SRC_NONE, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic expect_write(input string tag);
        wr_t e;
        chk({tag, "_en"}, 64'(o_wb_dest_en), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_reg"}, 64'(o_wb_dest_reg), 64'(e.rd));
            chk({tag, "_data"}, 64'(o_wb_dest_data), 64'(e.data));
        end else begin
            chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
        end
    endtask

    task automatic do_load(input string tag, input logic [MEM_OP_W-1:0] op,
                           input logic [REG_IDX_W-1:0] rd, input logic [WORD_W-1:0] addr,
                           input logic [WORD_W-1:0] rdata, input int waits,
                           input logic [WORD_W-1:0] exp_data);
        drive(1'b1, op, DEST_SRC_MEM, rd, addr, 32'h0000_0200);
        sb.push_back(wr_t'{rd, exp_data});
        tick();
        bubble();
        chk({tag, "_wait_en"}, 64'(o_wb_dest_en), 64'd0);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_stall"}, 64'(o_stall_req), 64'd1);
            if (i == waits - 1) begin
                i_dmem_rdata  = rdata;
                i_dmem_rvalid = 1'b1;
            end
            tick();
        end
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h5A5A_5A5A;
        chk({tag, "_stall_drop"}, 64'(o_stall_req), 64'd0);
        expect_write(tag);
        chk({tag, "_instret_pre"}, o_instret, exp_instret);
        tick();
        exp_instret = exp_instret + 64'd1;
        chk({tag, "_instret"}, o_instret, exp_instret);
        chk({tag, "_after_en"}, 64'(o_wb_dest_en), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_en", 64'(o_wb_dest_en), 64'd0);
        chk("rst_stall", 64'(o_stall_req), 64'd0);
        chk("rst_instret", o_instret, 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_reg", 64'(o_wb_dest_reg), 64'd0);
        chk("rst_data", 64'(o_wb_dest_data), 64'd0);
        #10 reset = 1'b0;
        tick();

        // ALU write to x5, then a bubble that must not count
        drive(1'b1, MEM_OP_NONE, DEST_SRC_ALU, 5'd5, 32'h1234_5678, 32'h0000_0100);
        sb.push_back(wr_t'{5'd5, 32'h1234_5678});
        tick();
        expect_write("alu");
        chk("alu_pc", 64'(o_pc), 64'h100);
        chk("alu_instr", 64'(o_instr), 64'h113);
        chk("alu_instret_pre", o_instret, exp_instret);
        bubble();
        tick();
        exp_instret = exp_instret + 64'd1;
        chk("alu_instret", o_instret, exp_instret);
        chk("bubble_en", 64'(o_wb_dest_en), 64'd0);
        tick();
        chk("bubble_instret", o_instret, exp_instret);

        // x0 destination: no write but still retires
        drive(1'b1, MEM_OP_NONE, DEST_SRC_ALU, 5'd0, 32'h0000_DEAD, 32'h0000_0104);
        tick();
        chk("x0_en", 64'(o_wb_dest_en), 64'd0);
        bubble();
        tick();
        exp_instret = exp_instret + 64'd1;
        chk("x0_instret", o_instret, exp_instret);

        // store (NONE destination) retires without a write or stall
        drive(1'b1, MEM_OP_SW, DEST_SRC_NONE, 5'd8, 32'h0000_3000, 32'h0000_0108);
        tick();
        chk("sw_en", 64'(o_wb_dest_en), 64'd0);
        chk("sw_stall", 64'(o_stall_req), 64'd0);
        bubble();
        tick();
        exp_instret = exp_instret + 64'd1;
        chk("sw_instret", o_instret, exp_instret);

        do_load("lb",  MEM_OP_LB,  5'd7,  32'h0000_1003, 32'h80FF_0102, 3, 32'hFFFF_FF80);
        do_load("lbu", MEM_OP_LBU, 5'd7,  32'h0000_1003, 32'h80FF_0102, 3, 32'h0000_0080);
        do_load("lh",  MEM_OP_LH,  5'd10, 32'h0000_1002, 32'h80FF_0102, 2, 32'hFFFF_80FF);
        do_load("lhu", MEM_OP_LHU, 5'd11, 32'h0000_1003, 32'h80FF_0102, 1, 32'h0000_80FF);
        do_load("lb0", MEM_OP_LB,  5'd12, 32'h0000_1000, 32'h80FF_0102, 1, 32'h0000_0002);
        do_load("lw",  MEM_OP_LW,  5'd13, 32'h0000_1003, 32'h80FF_0102, 1, 32'h80FF_0102);

        // clr abandons a pending load; the late response is ignored
        drive(1'b1, MEM_OP_LW, DEST_SRC_MEM, 5'd9, 32'h0000_2000, 32'h0000_0300);
        tick();
        chk("clr_stall_pre", 64'(o_stall_req), 64'd1);
        bubble();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_stall", 64'(o_stall_req), 64'd0);
        chk("clr_en", 64'(o_wb_dest_en), 64'd0);
        i_dmem_rdata  = 32'hCAFE_F00D;
        i_dmem_rvalid = 1'b1;
        tick();
        i_dmem_rvalid = 1'b0;
        chk("late_rvalid_en", 64'(o_wb_dest_en), 64'd0);
        chk("late_rvalid_stall", 64'(o_stall_req), 64'd0);
        tick();
        chk("clr_instret", o_instret, exp_instret);

        // stall holds an ALU write for 4 cycles; it retires once
        drive(1'b1, MEM_OP_NONE, DEST_SRC_ALU, 5'd3, 32'h0000_A5A5, 32'h0000_0400);
        sb.push_back(wr_t'{5'd3, 32'h0000_A5A5});
        tick();
        expect_write("hold");
        stall = 1'b1;
        drive(1'b1, MEM_OP_NONE, DEST_SRC_ALU, 5'd4, 32'h0000_BEEF, 32'h0000_0404);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_reg", 64'(o_wb_dest_reg), 64'd3);
            chk("hold_data", 64'(o_wb_dest_data), 64'h0000_A5A5);
        end
        exp_instret = exp_instret + 64'd1;
        chk("hold_instret", o_instret, exp_instret);
        stall = 1'b0;
        sb.push_back(wr_t'{5'd4, 32'h0000_BEEF});
        tick();
        expect_write("post_hold");
        chk("post_hold_instret", o_instret, exp_instret);
        bubble();
        tick();
        exp_instret = exp_instret + 64'd1;
        chk("post_hold_instret2", o_instret, exp_instret);

        // counter wrap from all-ones to zero
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.r_instret;
        #1;
        chk("wrap_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, MEM_OP_NONE, DEST_SRC_ALU, 5'd6, 32'h0000_0066, 32'h0000_0500);
        sb.push_back(wr_t'{5'd6, 32'h0000_0066});
        tick();
        expect_write("wrap");
        bubble();
        tick();
        exp_instret = 64'd0;
        chk("wrap_instret", o_instret, exp_instret);

        // asynchronous reset while a load is outstanding
        drive(1'b1, MEM_OP_LB, DEST_SRC_MEM, 5'd2, 32'h0000_0000, 32'h0000_0600);
        tick();
        bubble();
        chk("rstw_stall_pre", 64'(o_stall_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstw_stall", 64'(o_stall_req), 64'd0);
        chk("rstw_instret", o_instret, 64'd0);
        chk("rstw_en", 64'(o_wb_dest_en), 64'd0);
        chk("rstw_sb_drained", 64'(sb.size()), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb.md
# wb

Writeback stage of the five-stage pipeline: the producer side of the ID stage's register-file write port. It latches the retiring instruction from the MEM stage, waits on the data-memory read response for loads, extracts and extends load data, selects the destination source, and drives the single register-file write. It also raises a stall request while a load is outstanding and keeps a 64-bit retired-instruction counter.

## Interface

Parameters: none. Widths come from `config.vh`: `ADDR_W`, `INSTR_W`, `WORD_W` (32), `REG_IDX_W` (5), `MEM_OP_W`, `DEST_SRC_W`.

Ports:

- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous flush; pipeline registers become a bubble
- stall  in  1  hold pipeline registers; no new capture
- i_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- i_pc  in  ADDR_W  PC of the incoming instruction
- i_instr  in  INSTR_W  incoming instruction
- i_alu_result  in  WORD_W  ALU result; for loads, the byte address
- i_mem_op  in  MEM_OP_W  memory operation from the decoder
- i_dest_src  in  DEST_SRC_W  `DEST_SRC_NONE`, `DEST_SRC_ALU` or `DEST_SRC_MEM`
- i_dest_reg  in  REG_IDX_W  destination register index
- i_dmem_rdata  in  WORD_W  data-memory read word (aligned)
- i_dmem_rvalid  in  1  i_dmem_rdata is valid this cycle
- o_pc  out  ADDR_W  registered PC
- o_instr  out  INSTR_W  registered instruction
- o_wb_dest_en  out  1  register-file write enable
- o_wb_dest_reg  out  REG_IDX_W  register-file write index
- o_wb_dest_data  out  WORD_W  register-file write data
- o_stall_req  out  1  upstream must stall; a load is pending
- o_instret  out  64  count of retired instructions

## Operation

Pipeline registers: r_valid, r_pc, r_instr, r_alu, r_mem_op, r_dest_src, r_dest_reg. Load data register: r_ld.

Capture rules:
- Priority is reset > clr > hold > capture.
- The registers capture inputs when stall=0 and state is IDLE or LOAD_DONE.
- They hold when stall=1 or state is LOAD_WAIT.

State machine:
- **IDLE**: on capture of a valid load (`MEM_OP_LB/LH/LW/LBU/LHU`), go to LOAD_WAIT. Otherwise stay in IDLE.
- **LOAD_WAIT**: when i_dmem_rvalid=1 at a clock edge, capture the extracted data into r_ld and go to LOAD_DONE. Otherwise stay.
- **LOAD_DONE**: lasts exactly one cycle. The next state is LOAD_WAIT if a new load is captured, else IDLE.
- clr in any state: go to IDLE and make r_valid=0. A pending load is abandoned.
- i_dmem_rvalid is ignored outside LOAD_WAIT.

Load extraction (little-endian; offset = r_alu[1:0]):
- LB / LBU: byte at the offset, sign-extended / zero-extended to 32 bits.
- LH / LHU: halfword selected by r_alu[1]; r_alu[0] is ignored. Sign-extended / zero-extended.
- LW: the whole word; r_alu[1:0] is ignored.

Write path:
- o_wb_dest_reg = r_dest_reg.
- o_wb_dest_data = r_ld if r_dest_src=MEM, otherwise r_alu.
- o_wb_dest_en = r_valid AND r_dest_reg≠0 AND r_dest_src≠NONE AND state≠LOAD_WAIT.
- o_pc = r_pc; o_instr = r_instr.
- o_stall_req = 1 exactly when state=LOAD_WAIT.

Retired-instruction counter (o_instret):
- Increments by 1 at the edge that ends a cycle in which the stage holds a valid, non-waiting instruction. Stores, x0 destinations and NONE destinations count.
- A load counts once, in its LOAD_DONE cycle.
- While stall=1 and the stage holds the same instruction, count it only once. Use a per-instruction "counted" flag that is cleared on capture.
- Wraps from 2^64−1 to 0.

## Timing

- Reset values: all registers 0, state IDLE, o_wb_dest_en=0, o_stall_req=0, o_instret=0, o_pc=0, o_instr=0, o_wb_dest_reg=0, o_wb_dest_data=0.
- ALU/NONE instructions: captured at edge N. Write outputs are valid combinationally during cycle N..N+1. The register file writes at edge N+1.
- Loads: captured at edge N; o_stall_req=1 from cycle N. If rvalid is seen at edge M (M≥N+1), o_wb_dest_en=1 and o_stall_req=0 during cycle M..M+1. Minimum load latency is 2 cycles.
- The write-enable outputs are combinational from registers only; no input-to-output combinational path exists.

## Test plan

- **Reset during LOAD_WAIT**: assert reset mid-wait → state IDLE, o_stall_req=0, o_instret=0 immediately, with no clock needed.
- **ALU write**: capture valid, dest_src=ALU, dest_reg=5, alu=0x1234_5678 → next cycle en=1, reg=5, data=0x12345678. o_instret goes 0→1.
- **x0 suppression**: capture dest_reg=0, dest_src=ALU → en=0 while o_instret still increments. A bubble (i_valid=0) → en=0 and no increment.
- **LB sign-extend**: addr=0x1003, rdata=0x80FF_0102, rvalid after 3 wait cycles → o_stall_req high for 3 cycles, then en=1 with data=0xFFFF_FF80. With LBU the same stimulus gives 0x0000_0080. With LH at addr 0x1002 → 0xFFFF_80FF.
- **clr during LOAD_WAIT, then rvalid**: → state IDLE, en=0, o_stall_req=0, and the late rvalid is ignored (no write, no count).
- **Stall hold and counter wrap**: stall=1 for 4 cycles holding an ALU write → o_instret increments once. Preload the counter to 0xFFFF_FFFF_FFFF_FFFF, retire one instruction → 0.
